// File: rtl/duty_counter.sv
// Measures high-time and period of sig_i and hands them to the divider as count/dsor.
// Edge-to-sample latency SYNC_STAGES+2 clocks; a complete period is dropped while the divider is busy.
module duty_counter #(
  parameter int WIDTH       = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             en,
  input  logic             sig_i,
  input  logic             div_done,
  output logic             sample,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] dsor,
  output logic             overflow,
  output logic             dropped
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_q;
  logic                   rise_q;
  logic                   busy;
  logic                   free;
  logic [WIDTH-1:0]       per_cnt;
  logic [WIDTH-1:0]       hi_cnt;
  state_t                 state_q;
  state_t                 state_d;
  logic                   do_clear;
  logic                   do_load;
  logic                   do_count;
  logic                   do_report;
  logic                   do_drop;
  logic                   do_ovf;

  assign sig_s = sync_q[SYNC_STAGES-1];
  // A done arriving with the completing edge frees the divider in time for this report.
  assign free  = ~busy | div_done;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      sig_q  <= sig_s;
      rise_q <= sig_s & ~sig_q;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise_q) state_d = MEAS;
        MEAS:    if (!rise_q && per_cnt == CNT_MAX) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    do_clear  = 1'b0;
    do_load   = 1'b0;
    do_count  = 1'b0;
    do_report = 1'b0;
    do_drop   = 1'b0;
    do_ovf    = 1'b0;
    case (state_q)
      IDLE: do_clear = 1'b1;
      ARM:  do_load  = en & rise_q;
      MEAS: begin
        if (en) begin
          if (rise_q) begin
            do_load   = 1'b1;
            do_report = free;
            do_drop   = ~free;
          end else if (per_cnt == CNT_MAX) begin
            do_ovf = 1'b1;
          end else begin
            do_count = 1'b1;
          end
        end
      end
      default: do_clear = 1'b1;
    endcase
  end

  // sig_q is aligned with rise_q, so hi_cnt covers exactly the same cycles as per_cnt.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (do_clear) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (do_load) begin
      per_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      hi_cnt  <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (do_count) begin
      per_cnt <= per_cnt + 1'b1;
      if (sig_q) hi_cnt <= hi_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sample   <= 1'b0;
      dropped  <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
      dsor     <= '0;
      busy     <= 1'b0;
    end else begin
      sample   <= do_report;
      dropped  <= do_drop;
      overflow <= do_ovf;
      if (do_report) begin
        count <= hi_cnt;
        dsor  <= per_cnt;
      end
      if (do_report) busy <= 1'b1;
      else if (div_done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_duty_counter.sv
// Scoreboard bench for duty_counter (WIDTH=8 so saturation is reachable quickly).
module tb_duty_counter;
  localparam int W = 8;
  localparam int K_SAMPLE = 0;
  localparam int K_DROP   = 1;
  localparam int K_OVF    = 2;

  typedef struct {
    int kind;
    int cnt;
    int dsr;
    int at;
  } exp_t;

  logic         tb_clk = 1'b0;
  logic         RST;
  logic         en;
  logic         sig_i;
  logic         auto_p;
  logic         man_p;
  logic         auto_on;
  logic         stim_done;
  logic         div_done;
  logic         sample;
  logic         overflow;
  logic         dropped;
  logic [W-1:0] count;
  logic [W-1:0] dsor;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_c = 0;
  int   last_d = 0;
  exp_t exp_q[$];

  assign div_done = auto_p | man_p;

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  duty_counter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk      (tb_clk),
    .RST      (RST),
    .en       (en),
    .sig_i    (sig_i),
    .div_done (div_done),
    .sample   (sample),
    .count    (count),
    .dsor     (dsor),
    .overflow (overflow),
    .dropped  (dropped)
  );

  task automatic push(input int kind, input int c, input int d, input int at);
    exp_t e;
    e.kind = kind;
    e.cnt  = c;
    e.dsr  = d;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; sig_i holds v for exactly n sampling edges.
  task automatic hold(input logic v, input int n);
    sig_i = v;
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  // plan[2k+:2] says what the rising edge starting period k produces: 0 none, 1 sample, 2 drop.
  task automatic wave(input int hi, input int per, input int n, input logic [31:0] plan);
    for (int k = 0; k < n; k++) begin
      case (plan[2*k +: 2])
        2'd1: begin
          push(K_SAMPLE, hi, per, cyc + 4);
          last_c = hi;
          last_d = per;
        end
        2'd2: push(K_DROP, last_c, last_d, cyc + 4);
        default: ;
      endcase
      hold(1'b1, hi);
      hold(1'b0, per - hi);
    end
  endtask

  task automatic quiesce();
    en = 1'b0;
    hold(1'b0, 5);
    en = 1'b1;
    hold(1'b0, 5);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  initial begin
    auto_p = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (sample && auto_on) begin
        repeat (20) @(posedge tb_clk);
        #1 auto_p = 1'b1;
        @(posedge tb_clk);
        #1 auto_p = 1'b0;
      end
    end
  end

  initial begin
    RST = 1'b0; en = 1'b0; sig_i = 1'b0; man_p = 1'b0; auto_on = 1'b1; stim_done = 1'b0;
    repeat (4) @(posedge tb_clk);
    #1;
    RST = 1'b1;
    en  = 1'b1;
    hold(1'b0, 5);

    // square wave 40/100, then constant high (one report, then saturation) and constant low
    wave(40, 100, 4, 32'b01_01_01_00);
    push(K_SAMPLE, 40, 100, cyc + 4);
    last_c = 40; last_d = 100;
    push(K_OVF, 0, 0, cyc + 259);
    hold(1'b1, 400);
    hold(1'b0, 300);

    // asynchronous reset in the middle of a measurement
    hold(1'b1, 10);
    hold(1'b0, 5);
    @(posedge tb_clk);
    #3 RST = 1'b0;
    repeat (4) #2 sig_i = ~sig_i;
    sig_i = 1'b0;
    @(posedge tb_clk);
    #1;
    hold(1'b0, 3);
    RST = 1'b1;
    last_c = 0; last_d = 0;
    hold(1'b0, 5);
    wave(10, 20, 2, 32'b01_00);
    hold(1'b0, 30);
    quiesce();

    // divider busy: done withheld for ~120 cycles
    auto_on = 1'b0;
    fork
      wave(10, 50, 5, 32'b01_10_10_01_00);
      begin
        repeat (175) @(posedge tb_clk);
        #1 man_p = 1'b1;
        @(posedge tb_clk);
        #1 man_p = 1'b0;
      end
    join
    man_p = 1'b1;
    hold(1'b0, 1);
    man_p = 1'b0;
    quiesce();

    // done coincident with a completing edge keeps busy set
    wave(5, 10, 2, 32'b01_00);
    fork
      wave(5, 10, 2, 32'b10_01);
      begin
        repeat (3) @(posedge tb_clk);
        #1 man_p = 1'b1;
        @(posedge tb_clk);
        #1 man_p = 1'b0;
      end
    join
    man_p = 1'b1;
    hold(1'b0, 1);
    man_p = 1'b0;
    quiesce();

    // saturation at per_cnt = 255, then a 30-cycle period
    auto_on = 1'b1;
    push(K_OVF, 0, 0, cyc + 259);
    hold(1'b1, 3);
    hold(1'b0, 300);
    wave(10, 30, 2, 32'b01_00);
    hold(1'b0, 30);
    quiesce();

    // enable dropped mid-period, edge while disabled, then re-enable
    hold(1'b1, 10);
    hold(1'b0, 20);
    en = 1'b0;
    hold(1'b0, 3);
    hold(1'b1, 5);
    hold(1'b0, 5);
    en = 1'b1;
    hold(1'b0, 5);
    wave(10, 40, 2, 32'b01_00);
    hold(1'b0, 50);
    stim_done = 1'b1;
  end

  initial begin
    exp_t e;
    int   kind;
    while (!stim_done) begin
      @(negedge tb_clk);
      if (!RST) begin
        chk("rst_sample", int'(sample), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_dropped", int'(dropped), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_dsor", int'(dsor), 0);
      end else if (sample || dropped || overflow) begin
        chk("pulse_onehot", $countones({sample, dropped, overflow}), 1);
        kind = sample ? K_SAMPLE : (dropped ? K_DROP : K_OVF);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.at);
          if (e.kind != K_OVF) begin
            chk("count", int'(count), e.cnt);
            chk("dsor", int'(dsor), e.dsr);
          end
        end
      end
    end
    chk("events_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
